// File: rtl/ysyx_22040365_wb_stage_pkg.sv
// rtl/ysyx_22040365_wb_stage_pkg.sv - shared widths, load size codes and FSM state type for the WB stage
package ysyx_22040365_wb_stage_pkg;

    localparam int REG_BUS = 64;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/ysyx_22040365_load_ext.sv
// rtl/ysyx_22040365_load_ext.sv - byte-lane extraction and sign/zero extension of load data
module ysyx_22040365_load_ext
    import ysyx_22040365_wb_stage_pkg::*;
#(
    parameter int XLEN = REG_BUS
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_off,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    // Bytes shifted past the top of the word fill with zero, so misaligned loads simply read short.
    logic [XLEN-1:0] w_shifted;
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    // Select the access width and extend; dword loads have nothing to extend.
    always_comb begin
        o_data = w_shifted;
        case (i_size)
            LD_B: o_data = i_unsigned ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                      : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            LD_H: o_data = i_unsigned ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                      : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            LD_W: o_data = i_unsigned ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                                      : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040365_wb_stage.sv
// rtl/ysyx_22040365_wb_stage.sv - MEM/WB stage: load wait FSM, regfile write port and commit pulse
module ysyx_22040365_wb_stage
    import ysyx_22040365_wb_stage_pkg::*;
#(
    parameter int XLEN   = REG_BUS,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_45,
    input  logic              rd_en_45,
    input  logic [ADDR_W-1:0] rd_addr_45,
    input  logic [XLEN-1:0]   alu_res_45,
    input  logic              is_load_45,
    input  logic [1:0]        ld_size_45,
    input  logic              ld_unsigned_45,
    input  logic [XLEN-1:0]   pc_45,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall_wb,
    output logic              w_ena,
    output logic [ADDR_W-1:0] w_addr,
    output logic [XLEN-1:0]   w_data,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc
);

    wb_state_e         r_state;
    logic              r_pend_rd_en;
    logic [ADDR_W-1:0] r_pend_rd;
    logic [2:0]        r_pend_off;
    logic [1:0]        r_pend_size;
    logic              r_pend_uns;
    logic [XLEN-1:0]   r_pend_pc;

    logic              w_in_wait;
    logic [2:0]        w_ext_off;
    logic [1:0]        w_ext_size;
    logic              w_ext_uns;
    logic [XLEN-1:0]   w_ext_data;

    // The extender sees the latched load while waiting, otherwise the live EX/MEM load.
    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_ext_off  = w_in_wait ? r_pend_off  : alu_res_45[2:0];
    assign w_ext_size = w_in_wait ? r_pend_size : ld_size_45;
    assign w_ext_uns  = w_in_wait ? r_pend_uns  : ld_unsigned_45;

    ysyx_22040365_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .i_rdata    (mem_rdata),
        .i_off      (w_ext_off),
        .i_size     (w_ext_size),
        .i_unsigned (w_ext_uns),
        .o_data     (w_ext_data)
    );

    // Hold upstream while a load in flight has not yet seen its data.
    always_comb begin
        stall_wb = 1'b0;
        if (r_state == ST_IDLE)
            stall_wb = valid_45 && is_load_45 && !mem_rvalid;
        else
            stall_wb = !mem_rvalid;
    end

    // FSM, pending-load latch and registered write/commit outputs; one pulse per retired instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pend_rd_en <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_off   <= '0;
            r_pend_size  <= LD_B;
            r_pend_uns   <= 1'b0;
            r_pend_pc    <= ZERO_WORD;
            w_ena        <= 1'b0;
            w_addr       <= '0;
            w_data       <= ZERO_WORD;
            commit_valid <= 1'b0;
            commit_pc    <= ZERO_WORD;
        end else begin
            w_ena        <= 1'b0;
            commit_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_45 && (!is_load_45 || mem_rvalid)) begin
                        w_ena        <= rd_en_45 && (rd_addr_45 != '0);
                        w_addr       <= rd_addr_45;
                        w_data       <= is_load_45 ? w_ext_data : alu_res_45;
                        commit_valid <= 1'b1;
                        commit_pc    <= pc_45;
                    end else if (valid_45) begin
                        r_pend_rd_en <= rd_en_45;
                        r_pend_rd    <= rd_addr_45;
                        r_pend_off   <= alu_res_45[2:0];
                        r_pend_size  <= ld_size_45;
                        r_pend_uns   <= ld_unsigned_45;
                        r_pend_pc    <= pc_45;
                        r_state      <= ST_WAIT;
                    end
                end
                default: begin
                    if (mem_rvalid) begin
                        w_ena        <= r_pend_rd_en && (r_pend_rd != '0);
                        w_addr       <= r_pend_rd;
                        w_data       <= w_ext_data;
                        commit_valid <= 1'b1;
                        commit_pc    <= r_pend_pc;
                        r_state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
